data_path: RTL and testbench
============================

DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 nReset  input  1  asynchronous, active-low reset.
REQ-003 Ld  input  7  load enables, bit map [6:0] = FR, PSR, NPC, PC, MDR, MAR, IR.
REQ-004 nPC_Clr  input  1  synchronous clear of nPC.
REQ-005 RF_Load_Enable  input  1  register-file write enable.
REQ-006 RF_Clear_Enable  input  1  register-file single-entry clear.
REQ-007 Clear_Select  input  5  index of the entry cleared by RF_Clear_Enable.
REQ-008 Mux_Sel  input  9  selects, bit map [8:0] = MSa, MNP, MP, MM, MOP, MF, MC, MB, MA.
REQ-009 OpXX  input  6  externally supplied ALU opcode.
REQ-010 RW  input  1  memory direction: 1 = read, 0 = write.
REQ-011 MOV  input  1  memory operation valid.
REQ-012 type  input  2  access size: 00 = byte, 01 = halfword, 1x = word.
REQ-013 IR_Out  output  32  instruction register contents.
REQ-014 MAR_Out  output  32  memory address register contents.
REQ-015 MOC  output  1  memory operation complete.
REQ-016 BCOND, TCOND  output  1 each  branch and trap condition results.

Function
REQ-017 Register file SHALL be 32x32; r0 SHALL always read 0; two combinational read ports: rs1 = IR[18:14], rs2 = IR[4:0].
REQ-018 Write SHALL occur when RF_Load_Enable = 1; destination SHALL be IR[29:25] (MC = 0) or 15 (MC = 1); data SHALL be ALU result (MF = 0) or MDR (MF = 1).
REQ-019 RF_Clear_Enable SHALL zero entry Clear_Select, taking priority over a simultaneous write to any entry.
REQ-020 ALU operand A SHALL be RF[rs1] (MA = 0) or PC (MA = 1).
REQ-021 ALU operand B SHALL be MDR (MB = 1); otherwise sign-extended IR[12:0] if IR[13] = 1, else RF[rs2].
REQ-022 ALU opcode SHALL be OpXX (MOP = 0) or IR[24:19] (MOP = 1).
REQ-023 ALU ops on opcode[3:0] with opcode[5:4] = 00 or 01: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 SUB (A-B), 5 ANDN, 6 ORN, 7 XNOR.
REQ-024 ALU opcodes 100101, 100110 and 100111 SHALL be SLL, SRL and SRA by B[4:0]; any other opcode SHALL pass B.
REQ-025 ALU flags: N = result[31], Z = (result == 0); V and C SHALL be 32-bit two's-complement overflow and carry (borrow for SUB); V and C SHALL be 0 for logic and shift ops.
REQ-026 FR_Ld SHALL write the flags into PSR[23:20] = N, Z, V, C; PSR_Ld SHALL load PSR with the ALU result; FR_Ld SHALL win the icc bits when both are asserted.
REQ-027 IR, when loaded, SHALL take MDR; MAR SHALL take the ALU result (MSa = 0) or PC (MSa = 1).
REQ-028 MDR SHALL take memory read data (MM = 0) or RF[IR[29:25]] (MM = 1).
REQ-029 PC SHALL take nPC (MP = 0) or the ALU result (MP = 1).
REQ-030 nPC SHALL take nPC+4 (MNP = 0) or the ALU result (MNP = 1); nPC_Clr SHALL force nPC to 0 with priority over NPC load.
REQ-031 Memory SHALL be internal, 256 bytes, big-endian, addressed by MAR[7:0], with low address bits ignored for halfword and word accesses.
REQ-032 Memory reads SHALL be combinational and zero-extended to 32 bits.
REQ-033 A memory write SHALL occur on the clock edge where MOV = 1 and RW = 0, writing the low 1, 2 or 4 bytes of MDR.
REQ-034 MOC SHALL be a register loaded with MOV, so it is high one cycle after MOV is sampled.
REQ-035 BCOND SHALL evaluate the SPARC Bicc condition IR[28:25] against PSR icc (0000 = never, 1000 = always, others per the SPARC V8 table).

Reset
REQ-036 While nReset = 0: IR, MAR, MDR, PC, PSR, all RF entries and MOC SHALL be 0, and nPC SHALL be 4.
REQ-037 Memory contents SHALL NOT be reset.
REQ-038 Reset assertion mid-memory-access SHALL abort the write and clear MOC.

Configuration
REQ-039 With macro DATA_PATH_TCOND_EN defined, TCOND SHALL evaluate the same condition table on IR[28:25] for Ticc.
REQ-040 Without DATA_PATH_TCOND_EN, TCOND SHALL be constant 0.

Verification
REQ-041 Reset release -> PC = 0, nPC = 4, MAR_Out = 0, IR_Out = 0, MOC = 0.
REQ-042 Reset, then PC load (MP = 0) with nPC_Clr for 1 cycle -> PC = 4, nPC = 0.
REQ-043 MAR load, MSa = 1, PC = 4 -> MAR_Out = 4 next cycle.
REQ-044 Word write of MDR = 0xDEADBEEF to address 8 with MOV, then word read into MDR and IR load -> IR_Out = 0xDEADBEEF; MOC high one cycle after each MOV.
REQ-045 OpXX = SUB (000100) with equal operands and FR_Ld, then IR[28:25] = 0001 (BE) -> BCOND = 1.
REQ-046 RF_Clear_Enable with Clear_Select = 5 and a simultaneous write to r5 -> r5 reads 0.

Source files
------------

// File: rtl/data_path.sv
// data_path: SPARC-style processor datapath.
// Contents: 32x32 register file, ALU with condition flags, IR/MAR/MDR/PC/nPC/PSR
// registers, a 256-byte big-endian internal memory and branch condition evaluation.
// Optional build macro DATA_PATH_TCOND_EN: when defined, TCOND evaluates the Ticc
// condition; otherwise TCOND is tied low.
module data_path #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic [6:0]        Ld,
    input  logic              nPC_Clr,
    input  logic              RF_Load_Enable,
    input  logic              RF_Clear_Enable,
    input  logic [4:0]        Clear_Select,
    input  logic [8:0]        Mux_Sel,
    input  logic [5:0]        OpXX,
    input  logic              RW,
    input  logic              MOV,
    // Access size; capitalised because the lowercase name is a reserved word.
    input  logic [1:0]        Type,
    output logic [DATA_W-1:0] IR_Out,
    output logic [DATA_W-1:0] MAR_Out,
    output logic              MOC,
    output logic              BCOND,
    output logic              TCOND
);

    // Evaluate a Bicc/Ticc condition code against icc = {N, Z, V, C}.
    // The upper cond bit inverts the lower-half condition.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] icc);
        logic n, z, v, c, base;
        {n, z, v, c} = icc;
        case (cond[2:0])
            3'd0:    base = 1'b0;
            3'd1:    base = z;
            3'd2:    base = z | (n ^ v);
            3'd3:    base = n ^ v;
            3'd4:    base = c | z;
            3'd5:    base = c;
            3'd6:    base = n;
            default: base = v;
        endcase
        return cond[3] ? ~base : base;
    endfunction

    logic ld_fr, ld_psr, ld_npc, ld_pc, ld_mdr, ld_mar, ld_ir;
    logic m_sa, m_np, m_p, m_m, m_op, m_f, m_c, m_b, m_a;

    assign {ld_fr, ld_psr, ld_npc, ld_pc, ld_mdr, ld_mar, ld_ir} = Ld;
    assign {m_sa, m_np, m_p, m_m, m_op, m_f, m_c, m_b, m_a}     = Mux_Sel;

    logic [DATA_W-1:0] ir, mar, mdr, pc, npc, psr;
    logic              moc;
    logic [DATA_W-1:0] rf  [32];
    logic [7:0]        mem [256];

    // Register file read ports; r0 always reads zero.
    logic [4:0]        rs1, rs2, rd;
    logic [DATA_W-1:0] rs1_data, rs2_data, rd_data;

    assign rs1      = ir[18:14];
    assign rs2      = ir[4:0];
    assign rd       = ir[29:25];
    assign rs1_data = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rs2_data = (rs2 == 5'd0) ? '0 : rf[rs2];
    assign rd_data  = (rd  == 5'd0) ? '0 : rf[rd];

    // ALU operand and opcode selection.
    logic signed [DATA_W-1:0] alu_a, alu_b, imm_sext;
    logic        [5:0]        alu_op;

    assign imm_sext = {{(DATA_W-13){ir[12]}}, ir[12:0]};
    assign alu_a    = m_a ? pc : rs1_data;
    assign alu_b    = m_b ? mdr : (ir[13] ? imm_sext : rs2_data);
    assign alu_op   = m_op ? ir[24:19] : OpXX;

    logic [DATA_W:0]   sum_x, dif_x;
    logic [DATA_W-1:0] alu_res;
    logic              flag_n, flag_z, flag_v, flag_c;

    assign sum_x = {1'b0, alu_a} + {1'b0, alu_b};
    assign dif_x = {1'b0, alu_a} - {1'b0, alu_b};

    // ALU: arithmetic produces V/C (C is borrow on SUB); logic, shift and pass-B clear them.
    always_comb begin
        alu_res = alu_b;
        flag_v  = 1'b0;
        flag_c  = 1'b0;
        if (alu_op[5] == 1'b0) begin
            case (alu_op[3:0])
                4'd0: begin
                    alu_res = sum_x[DATA_W-1:0];
                    flag_c  = sum_x[DATA_W];
                    flag_v  = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                              (sum_x[DATA_W-1] != alu_a[DATA_W-1]);
                end
                4'd1: alu_res = alu_a & alu_b;
                4'd2: alu_res = alu_a | alu_b;
                4'd3: alu_res = alu_a ^ alu_b;
                4'd4: begin
                    alu_res = dif_x[DATA_W-1:0];
                    flag_c  = dif_x[DATA_W];
                    flag_v  = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                              (dif_x[DATA_W-1] != alu_a[DATA_W-1]);
                end
                4'd5: alu_res = alu_a & ~alu_b;
                4'd6: alu_res = alu_a | ~alu_b;
                4'd7: alu_res = ~(alu_a ^ alu_b);
                default: alu_res = alu_b;
            endcase
        end else if (alu_op == 6'b100101) begin
            alu_res = alu_a <<< alu_b[4:0];
        end else if (alu_op == 6'b100110) begin
            alu_res = $unsigned(alu_a) >> alu_b[4:0];
        end else if (alu_op == 6'b100111) begin
            alu_res = alu_a >>> alu_b[4:0];
        end
    end

    assign flag_n = alu_res[DATA_W-1];
    assign flag_z = (alu_res == '0);

    // Next PSR: full load from the ALU, then flag load overrides the icc field.
    logic [DATA_W-1:0] psr_next;
    always_comb begin
        psr_next = psr;
        if (ld_psr) psr_next = alu_res;
        if (ld_fr)  psr_next[23:20] = {flag_n, flag_z, flag_v, flag_c};
    end

    // Memory addressing: halfword and word accesses drop the low address bits.
    logic [7:0]        mem_a0, mem_a1, mem_a2, mem_a3;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;

    assign mem_a0 = Type[1] ? {mar[7:2], 2'b00} : (Type[0] ? {mar[7:1], 1'b0} : mar[7:0]);
    assign mem_a1 = mem_a0 + 8'd1;
    assign mem_a2 = mem_a0 + 8'd2;
    assign mem_a3 = mem_a0 + 8'd3;
    assign mem_we = MOV && !RW;

    // Combinational big-endian read, zero-extended for byte and halfword.
    always_comb begin
        mem_rdata = '0;
        if (Type[1])      mem_rdata = {mem[mem_a0], mem[mem_a1], mem[mem_a2], mem[mem_a3]};
        else if (Type[0]) mem_rdata = {16'd0, mem[mem_a0], mem[mem_a1]};
        else              mem_rdata = {24'd0, mem[mem_a0]};
    end

    // Memory write of the low bytes of MDR; contents survive reset, and a write
    // pending while reset is asserted is dropped.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            // contents intentionally preserved
        end else if (mem_we) begin
            if (Type[1]) begin
                mem[mem_a0] <= mdr[31:24];
                mem[mem_a1] <= mdr[23:16];
                mem[mem_a2] <= mdr[15:8];
                mem[mem_a3] <= mdr[7:0];
            end else if (Type[0]) begin
                mem[mem_a0] <= mdr[15:8];
                mem[mem_a1] <= mdr[7:0];
            end else begin
                mem[mem_a0] <= mdr[7:0];
            end
        end
    end

    // Register file write: single-entry clear beats any load; r0 is never written.
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    assign rf_waddr = m_c ? 5'd15 : rd;
    assign rf_wdata = m_f ? mdr : alu_res;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (RF_Clear_Enable) begin
            rf[Clear_Select] <= '0;
        end else if (RF_Load_Enable && (rf_waddr != 5'd0)) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // Instruction/memory interface registers and the operation-complete flag.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            moc <= 1'b0;
        end else begin
            moc <= MOV;
            if (ld_ir)  ir  <= mdr;
            if (ld_mar) mar <= m_sa ? pc : alu_res;
            if (ld_mdr) mdr <= m_m ? rd_data : mem_rdata;
        end
    end

    // Program counters and status register; nPC clear overrides an nPC load.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            pc  <= '0;
            npc <= DATA_W'(4);
            psr <= '0;
        end else begin
            if (ld_pc) pc <= m_p ? alu_res : npc;
            if (nPC_Clr)     npc <= '0;
            else if (ld_npc) npc <= m_np ? alu_res : npc + DATA_W'(4);
            if (ld_fr || ld_psr) psr <= psr_next;
        end
    end

    assign IR_Out  = ir;
    assign MAR_Out = mar;
    assign MOC     = moc;
    assign BCOND   = cond_eval(ir[28:25], psr[23:20]);

`ifdef DATA_PATH_TCOND_EN
    assign TCOND = cond_eval(ir[28:25], psr[23:20]);
`else
    assign TCOND = 1'b0;
`endif

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed self-checking bench for data_path.
module tb_data_path;

    logic        Clk;
    logic        nReset;
    logic [6:0]  Ld;
    logic        nPC_Clr;
    logic        RF_Load_Enable;
    logic        RF_Clear_Enable;
    logic [4:0]  Clear_Select;
    logic [8:0]  Mux_Sel;
    logic [5:0]  OpXX;
    logic        RW;
    logic        MOV;
    logic [1:0]  Type;
    logic [31:0] IR_Out;
    logic [31:0] MAR_Out;
    logic        MOC;
    logic        BCOND;
    logic        TCOND;

    localparam logic [6:0] LD_FR  = 7'b1000000;
    localparam logic [6:0] LD_NPC = 7'b0010000;
    localparam logic [6:0] LD_PC  = 7'b0001000;
    localparam logic [6:0] LD_MDR = 7'b0000100;
    localparam logic [6:0] LD_MAR = 7'b0000010;
    localparam logic [6:0] LD_IR  = 7'b0000001;

    localparam logic [8:0] M_SA = 9'h100;
    localparam logic [8:0] M_M  = 9'h020;
    localparam logic [8:0] M_F  = 9'h008;
    localparam logic [8:0] M_C  = 9'h004;
    localparam logic [8:0] M_B  = 9'h002;
    localparam logic [8:0] M_A  = 9'h001;

`ifdef DATA_PATH_TCOND_EN
    localparam bit TC_EN = 1'b1;
`else
    localparam bit TC_EN = 1'b0;
`endif

    int ntests = 0;
    int nfail  = 0;

    logic [31:0] frc_mar;
    logic [31:0] frc_mdr;

    data_path dut (
        .Clk             (Clk),
        .nReset          (nReset),
        .Ld              (Ld),
        .nPC_Clr         (nPC_Clr),
        .RF_Load_Enable  (RF_Load_Enable),
        .RF_Clear_Enable (RF_Clear_Enable),
        .Clear_Select    (Clear_Select),
        .Mux_Sel         (Mux_Sel),
        .OpXX            (OpXX),
        .RW              (RW),
        .MOV             (MOV),
        .Type            (Type),
        .IR_Out          (IR_Out),
        .MAR_Out         (MAR_Out),
        .MOC             (MOC),
        .BCOND           (BCOND),
        .TCOND           (TCOND)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Store a value into memory through the real write port, presetting MAR/MDR.
    task automatic poke(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
        frc_mar = addr;
        frc_mdr = data;
        force dut.mar = frc_mar;
        force dut.mdr = frc_mdr;
        Ld = '0; Mux_Sel = '0; Type = sz; RW = 1'b0; MOV = 1'b1;
        tick();
        release dut.mar;
        release dut.mdr;
        MOV = 1'b0; RW = 1'b1;
    endtask

    // Read memory at a preset address into MDR, then move MDR into IR.
    task automatic read_to_ir(input logic [31:0] addr, input logic [1:0] sz);
        frc_mar = addr;
        force dut.mar = frc_mar;
        Ld = LD_MDR; Mux_Sel = '0; Type = sz; MOV = 1'b0; RW = 1'b1;
        tick();
        release dut.mar;
        Ld = LD_IR;
        tick();
        Ld = '0;
    endtask

    initial begin
        nReset = 1'b0; Ld = '0; nPC_Clr = 1'b0; RF_Load_Enable = 1'b0;
        RF_Clear_Enable = 1'b0; Clear_Select = '0; Mux_Sel = '0; OpXX = '0;
        RW = 1'b1; MOV = 1'b0; Type = 2'b10; frc_mar = '0; frc_mdr = '0;

        // Reset state
        #12;
        check("rst_ir", IR_Out, 32'h0);
        check("rst_mar", MAR_Out, 32'h0);
        check("rst_moc", {31'd0, MOC}, 32'h0);
        check("rst_pc", dut.pc, 32'h0);
        check("rst_npc", dut.npc, 32'h4);
        nReset = 1'b1;
        tick();
        check("rel_pc", dut.pc, 32'h0);
        check("rel_npc", dut.npc, 32'h4);
        check("rel_mar", MAR_Out, 32'h0);

        // PC from nPC with simultaneous nPC clear
        Ld = LD_PC; nPC_Clr = 1'b1;
        tick();
        Ld = '0; nPC_Clr = 1'b0;
        check("pc_from_npc", dut.pc, 32'h4);
        check("npc_clr", dut.npc, 32'h0);

        // MAR from PC
        Ld = LD_MAR; Mux_Sel = M_SA;
        tick();
        Ld = '0; Mux_Sel = '0;
        check("mar_from_pc", MAR_Out, 32'h4);

        // Preload instruction words
        poke(32'h10, 32'h0200_0000, 2'b10);
        poke(32'h14, 32'h0A00_0000, 2'b10);
        poke(32'h18, 32'h1200_0000, 2'b10);

        // nPC increments, PC <- nPC, MAR <- PC = 8
        Ld = LD_NPC;
        tick();
        tick();
        check("npc_inc", dut.npc, 32'h8);
        Ld = LD_PC;
        tick();
        Ld = LD_MAR; Mux_Sel = M_SA;
        tick();
        Ld = '0; Mux_Sel = '0;
        check("mar_8", MAR_Out, 32'h8);

        // Word write of 0xDEADBEEF to address 8
        frc_mdr = 32'hDEAD_BEEF;
        force dut.mdr = frc_mdr;
        MOV = 1'b1; RW = 1'b0; Type = 2'b10;
        tick();
        release dut.mdr;
        MOV = 1'b0; RW = 1'b1;
        check("moc_after_wr", {31'd0, MOC}, 32'h1);
        Ld = LD_MDR; Mux_Sel = M_M;
        tick();
        check("moc_drop", {31'd0, MOC}, 32'h0);
        check("mdr_cleared", dut.mdr, 32'h0);

        // Word read back, then IR load
        Ld = LD_MDR; Mux_Sel = '0; MOV = 1'b1; RW = 1'b1;
        tick();
        MOV = 1'b0;
        check("moc_after_rd", {31'd0, MOC}, 32'h1);
        Ld = LD_IR;
        tick();
        Ld = '0;
        check("ir_deadbeef", IR_Out, 32'hDEAD_BEEF);

        // ALU: pass-B with sign-extended immediate, SLL, ORN (results via MAR)
        Ld = LD_MAR; Mux_Sel = '0; OpXX = 6'b001000;
        tick();
        check("alu_passb_sext", MAR_Out, 32'hFFFF_FEEF);
        Mux_Sel = M_A; OpXX = 6'b100101;
        tick();
        check("alu_sll", MAR_Out, 32'h0004_0000);
        OpXX = 6'b000110;
        tick();
        Ld = '0; Mux_Sel = '0;
        check("alu_orn", MAR_Out, 32'h0000_0118);

        // Narrow reads with low address bits ignored
        read_to_ir(32'h0B, 2'b00);
        check("rd_byte_b", IR_Out, 32'h0000_00EF);
        read_to_ir(32'h0B, 2'b01);
        check("rd_half_b", IR_Out, 32'h0000_BEEF);
        read_to_ir(32'h09, 2'b00);
        check("rd_byte_9", IR_Out, 32'h0000_00AD);

        // Narrow writes then word read (type 11 is word)
        poke(32'h0B, 32'h1234_5678, 2'b01);
        poke(32'h09, 32'hCAFE_00AB, 2'b00);
        read_to_ir(32'h0B, 2'b11);
        check("rd_word_merged", IR_Out, 32'hDEAB_5678);

        // Branch conditions
        read_to_ir(32'h10, 2'b10);
        check("be_before_sub", {31'd0, BCOND}, 32'h0);
        OpXX = 6'b000100; Mux_Sel = '0; Ld = LD_FR;
        tick();
        Ld = '0;
        check("be_after_sub", {31'd0, BCOND}, 32'h1);
        check("tcond_be", {31'd0, TCOND}, {31'd0, TC_EN});
        read_to_ir(32'h18, 2'b10);
        check("bne_z", {31'd0, BCOND}, 32'h0);
        read_to_ir(32'h14, 2'b10);
        check("bcs_no_c", {31'd0, BCOND}, 32'h0);
        OpXX = 6'b000100; Mux_Sel = M_B; Ld = LD_FR | LD_MAR;
        tick();
        Ld = '0; Mux_Sel = '0;
        check("sub_borrow_res", MAR_Out, 32'hF600_0000);
        check("bcs_c", {31'd0, BCOND}, 32'h1);

        // Register file write paths and clear priority (IR dest = r5)
        RF_Load_Enable = 1'b1; Mux_Sel = M_A; OpXX = 6'b000000;
        tick();
        check("rf_r5_alu", dut.rf[5], 32'h8);
        Mux_Sel = M_F | M_C;
        tick();
        check("rf_r15_mdr", dut.rf[15], 32'h0A00_0000);
        Mux_Sel = M_A; RF_Clear_Enable = 1'b1; Clear_Select = 5'd5;
        tick();
        RF_Load_Enable = 1'b0; RF_Clear_Enable = 1'b0; Mux_Sel = '0;
        check("rf_clear_wins", dut.rf[5], 32'h0);
        check("rf_r15_kept", dut.rf[15], 32'h0A00_0000);

        // Reset asserted during a pending write to address 8
        Ld = LD_MDR; Mux_Sel = M_M;
        tick();
        Ld = '0; Mux_Sel = '0; MOV = 1'b1; RW = 1'b1; Type = 2'b10;
        tick();
        check("moc_pre_rst", {31'd0, MOC}, 32'h1);
        frc_mar = 32'h8;
        force dut.mar = frc_mar;
        RW = 1'b0;
        #1 nReset = 1'b0;
        #1;
        check("moc_async_clr", {31'd0, MOC}, 32'h0);
        check("ir_async_clr", IR_Out, 32'h0);
        tick();
        release dut.mar;
        tick();
        check("moc_in_rst", {31'd0, MOC}, 32'h0);
        check("mar_in_rst", MAR_Out, 32'h0);
        check("npc_in_rst", dut.npc, 32'h4);
        nReset = 1'b1; MOV = 1'b0; RW = 1'b1;

        // Memory survives reset and the aborted write
        Ld = LD_PC | LD_NPC;
        tick();
        check("pc_after_rst", dut.pc, 32'h4);
        Ld = LD_PC;
        tick();
        Ld = LD_MAR; Mux_Sel = M_SA;
        tick();
        Ld = LD_MDR; Mux_Sel = '0; Type = 2'b10;
        tick();
        Ld = LD_IR;
        tick();
        Ld = '0;
        check("mem_kept", IR_Out, 32'hDEAB_5678);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
